// File: rtl/db_read_addr_gen_if.sv
// Read-address bus between the address generator and the double-buffer read port.
// The generator is the master. The memory side (the slave) returns addr_ready.
interface db_read_addr_gen_if #(
    parameter int ADDR_W = 16
) ();
    logic [ADDR_W-1:0] addr_out;
    logic              addr_valid;
    logic              addr_ready;

    modport master (output addr_out, output addr_valid, input addr_ready);
    modport slave  (input addr_out, input addr_valid, output addr_ready);
endinterface

// File: rtl/db_read_addr_gen.sv
// Nested-loop (odometer) read-address generator that drains one double-buffer bank per pass.
// Addresses are built from per-dimension offset registers that are stepped by adding the stride, so no multipliers are used.
module db_read_addr_gen #(
    parameter int ADDR_W = 16,
    parameter int RNG_W  = 32,
    parameter int NDIM   = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_en,
    input  logic                   flush,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      starting_addr,
    input  logic [3:0]             dimensionality,
    input  logic [NDIM*ADDR_W-1:0] strides,
    input  logic [NDIM*RNG_W-1:0]  ranges,
    db_read_addr_gen_if.master     rd,
    output logic                   busy,
    output logic                   done,
    output logic [RNG_W-1:0]       issued
);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [RNG_W-1:0] ONE_R = RNG_W'(1);

    state_t              r_state, w_state_next;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_addr, w_addr_next;
    logic [3:0]          r_dim, w_dim_clamped;
    logic                r_valid, w_valid_next;
    logic                r_busy, w_busy_next;
    logic                r_done, w_done_next;
    logic [RNG_W-1:0]    r_issued, w_issued_next;
    logic                w_step, w_load, w_last;

    logic [NDIM:0]       w_carry;
    logic [ADDR_W-1:0]   w_sum [NDIM+1];

    assign w_carry[0] = 1'b1;
    assign w_sum[0]   = r_base;
    assign w_last     = w_carry[NDIM];

    // Each dimension owns its index and running offset (idx*stride). Inactive
    // dimensions count as "at max" so the carry passes through them.
    generate
        for (genvar gi = 0; gi < NDIM; gi++) begin : g_dim
            logic [ADDR_W-1:0] r_stride;
            logic [RNG_W-1:0]  r_range_m1;
            logic [RNG_W-1:0]  r_idx, w_idx_step;
            logic [ADDR_W-1:0] r_off, w_off_step;
            logic [RNG_W-1:0]  w_range_in;
            logic              w_active, w_at_max;

            assign w_range_in = ranges[gi*RNG_W +: RNG_W];
            assign w_active   = (4'(gi) < r_dim);
            assign w_at_max   = !w_active || (r_idx == r_range_m1);
            assign w_carry[gi+1] = w_carry[gi] & w_at_max;

            always_comb begin
                w_idx_step = r_idx;
                w_off_step = r_off;
                if (w_active && w_carry[gi]) begin
                    if (w_at_max) begin
                        w_idx_step = '0;
                        w_off_step = '0;
                    end else begin
                        w_idx_step = r_idx + ONE_R;
                        w_off_step = r_off + r_stride;
                    end
                end
            end

            assign w_sum[gi+1] = w_sum[gi] + w_off_step;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_stride   <= '0;
                    r_range_m1 <= '0;
                    r_idx      <= '0;
                    r_off      <= '0;
                end else if (flush) begin
                    r_idx <= '0;
                    r_off <= '0;
                end else if (w_load) begin
                    r_stride   <= strides[gi*ADDR_W +: ADDR_W];
                    r_range_m1 <= (w_range_in == '0) ? '0 : (w_range_in - ONE_R);
                    r_idx      <= '0;
                    r_off      <= '0;
                end else if (w_step) begin
                    r_idx <= w_idx_step;
                    r_off <= w_off_step;
                end
            end
        end
    endgenerate

    always_comb begin
        w_dim_clamped = dimensionality;
        if (dimensionality == 4'd0) begin
            w_dim_clamped = 4'd1;
        end else if (dimensionality > 4'(NDIM)) begin
            w_dim_clamped = 4'(NDIM);
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_addr_next   = r_addr;
        w_valid_next  = r_valid;
        w_busy_next   = r_busy;
        w_done_next   = 1'b0;
        w_issued_next = r_issued;
        w_load        = 1'b0;
        w_step        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && clk_en) begin
                    w_load        = 1'b1;
                    w_state_next  = S_RUN;
                    w_addr_next   = starting_addr;
                    w_valid_next  = 1'b1;
                    w_busy_next   = 1'b1;
                    w_issued_next = '0;
                end
            end
            S_RUN: begin
                w_step = r_valid && rd.addr_ready && clk_en;
                if (w_step) begin
                    w_issued_next = r_issued + ONE_R;
                    if (w_last) begin
                        w_done_next  = 1'b1;
                        w_valid_next = 1'b0;
                        w_busy_next  = 1'b0;
                        w_state_next = S_IDLE;
                    end else begin
                        w_addr_next = w_sum[NDIM];
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // done is a pure pulse: it is recomputed every cycle rather than held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_base   <= '0;
            r_dim    <= '0;
            r_addr   <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_issued <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_addr   <= w_addr_next;
            r_valid  <= w_valid_next;
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
            r_issued <= w_issued_next;
            if (w_load) begin
                r_base <= starting_addr;
                r_dim  <= w_dim_clamped;
            end
        end
    end

    assign rd.addr_out   = r_addr;
    assign rd.addr_valid = r_valid;
    assign busy          = r_busy;
    assign done          = r_done;
    assign issued        = r_issued;

endmodule

// File: tb/tb_db_read_addr_gen.sv
// Scoreboard bench for db_read_addr_gen: stimulus queues expected addresses, a negedge monitor
// pops and compares them on every accepted address and checks the done pulse.
module tb_db_read_addr_gen;
    localparam int ADDR_W = 16;
    localparam int RNG_W  = 32;
    localparam int NDIM   = 6;

    logic                   clk = 1'b0;
    logic                   reset, clk_en, flush, start;
    logic [ADDR_W-1:0]      starting_addr;
    logic [3:0]             dimensionality;
    logic [NDIM*ADDR_W-1:0] strides;
    logic [NDIM*RNG_W-1:0]  ranges;
    logic                   busy, done;
    logic [RNG_W-1:0]       issued;

    db_read_addr_gen_if #(.ADDR_W(ADDR_W)) rd_if ();

    db_read_addr_gen #(.ADDR_W(ADDR_W), .RNG_W(RNG_W), .NDIM(NDIM)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .start(start),
        .starting_addr(starting_addr), .dimensionality(dimensionality),
        .strides(strides), .ranges(ranges), .rd(rd_if.master),
        .busy(busy), .done(done), .issued(issued)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              last;
    } exp_t;

    exp_t              exp_q[$];
    int                checks = 0;
    int                errors = 0;
    int                acc_cnt = 0;
    bit                saw_done = 0;
    bit                pend_done = 0;
    bit                hold_pending = 0;
    bit                drop_start_on_done = 0;
    logic [ADDR_W-1:0] held_addr;
    exp_t              mon_e;
    bit                mon_acc;

    // Monitor: done must appear exactly on the negedge after the last accept.
    always @(negedge clk) begin
        checks++;
        if (done !== pend_done) begin
            errors++;
            $display("FAIL done_pulse: got %0b want %0b at %0t", done, pend_done, $time);
        end
        if (done) begin
            saw_done = 1;
            if (drop_start_on_done) begin
                start = 1'b0;
                drop_start_on_done = 0;
            end
        end
        pend_done = 0;
        if (rd_if.addr_valid && hold_pending) begin
            checks++;
            if (rd_if.addr_out !== held_addr) begin
                errors++;
                $display("FAIL hold_stable: got %h want %h", rd_if.addr_out, held_addr);
            end
        end
        mon_acc = rd_if.addr_valid && rd_if.addr_ready && clk_en && !reset && !flush;
        hold_pending = rd_if.addr_valid && !mon_acc;
        held_addr = rd_if.addr_out;
        if (mon_acc) begin
            checks++;
            acc_cnt++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_addr: got %h want none", rd_if.addr_out);
            end else begin
                mon_e = exp_q.pop_front();
                pend_done = mon_e.last;
                if (rd_if.addr_out !== mon_e.addr) begin
                    errors++;
                    $display("FAIL addr #%0d: got %h want %h", acc_cnt, rd_if.addr_out, mon_e.addr);
                end else begin
                    $display("accept #%0d addr=%h last=%0b", acc_cnt, rd_if.addr_out, mon_e.last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end else begin
            $display("check %s = %h", name, got);
        end
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input bit last);
        exp_t e;
        e.addr = a;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic start_pass(input bit hold);
        acc_cnt  = 0;
        saw_done = 0;
        start    = 1'b1;
        tick();
        if (!hold) start = 1'b0;
    endtask

    // mode 1: addr_ready pattern 1,0,0,1,... and clk_en low for two cycles mid-pass
    task automatic wait_done(input int budget, input int mode, output int cyc);
        cyc = 0;
        while (!saw_done && cyc < budget) begin
            tick();
            cyc++;
            if (mode == 1) begin
                rd_if.addr_ready = (cyc % 3 == 0);
                clk_en = !(cyc == 12 || cyc == 13);
            end
        end
        if (!saw_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done want done within %0d cycles", budget);
        end
        rd_if.addr_ready = 1'b1;
        clk_en = 1'b1;
    endtask

    task automatic end_checks(input string name, input logic [31:0] want_issued);
        chk({name, "_valid_after"}, 32'(rd_if.addr_valid), 32'd0);
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
        chk({name, "_issued"}, issued, want_issued);
        chk({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic cfg_cube();
        starting_addr  = 16'h0000;
        dimensionality = 4'd3;
        strides = {16'd0, 16'd0, 16'd0, 16'd9, 16'd3, 16'd1};
        ranges  = {32'd1, 32'd1, 32'd1, 32'd3, 32'd3, 32'd3};
    endtask

    task automatic push_cube();
        for (int i = 0; i < 27; i++) push(16'(i), i == 26);
    endtask

    task automatic cfg_2x2();
        starting_addr  = 16'd5;
        dimensionality = 4'd2;
        strides = {16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd3};
        ranges  = {32'd1, 32'd1, 32'd1, 32'd1, 32'd2, 32'd2};
    endtask

    task automatic push_2x2();
        push(16'd5, 0); push(16'd8, 0); push(16'd6, 0); push(16'd9, 1);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_addr"}, 32'(rd_if.addr_out), 32'd0);
        chk({name, "_valid"}, 32'(rd_if.addr_valid), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_issued"}, issued, 32'd0);
    endtask

    initial begin
        int cyc;
        reset = 1'b1; clk_en = 1'b1; flush = 1'b0; start = 1'b0;
        starting_addr = '0; dimensionality = '0; strides = '0; ranges = '0;
        rd_if.addr_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check_idle_outputs("reset");

        // 3-D cube, full throughput: first address one cycle after start
        cfg_cube(); push_cube();
        start_pass(0);
        wait_done(40, 0, cyc);
        chk("cube_pass_cycles", 32'(cyc), 32'd28);
        end_checks("cube", 32'd27);

        // 2x2 with swapped strides and non-zero base
        cfg_2x2(); push_2x2();
        start_pass(0);
        wait_done(20, 0, cyc);
        end_checks("2x2", 32'd4);

        // Backpressure and clk_en gaps must not change sequence or count
        cfg_cube(); push_cube();
        start_pass(0);
        wait_done(200, 1, cyc);
        end_checks("cube_bp", 32'd27);

        // Flush after 10 accepts
        cfg_cube(); push_cube();
        start_pass(0);
        cyc = 0;
        while (acc_cnt != 10 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("flush_reached_10", 32'(acc_cnt), 32'd10);
        flush = 1'b1;
        rd_if.addr_ready = 1'b0;
        tick();
        flush = 1'b0;
        rd_if.addr_ready = 1'b1;
        chk("flush_valid", 32'(rd_if.addr_valid), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_issued", issued, 32'd10);
        exp_q.delete();
        repeat (3) tick();
        chk("flush_stays_idle", 32'(rd_if.addr_valid), 32'd0);
        cfg_cube(); push_cube();
        start_pass(0);
        wait_done(40, 0, cyc);
        end_checks("after_flush", 32'd27);

        // Silent wrap past 0xFFFF
        starting_addr = 16'hFFFE; dimensionality = 4'd1;
        strides = {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
        ranges  = {32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd4};
        push(16'hFFFE, 0); push(16'hFFFF, 0); push(16'h0000, 0); push(16'h0001, 1);
        start_pass(0);
        wait_done(20, 0, cyc);
        end_checks("wrap", 32'd4);

        // range_0 = 0 is one address
        starting_addr = 16'h1234; dimensionality = 4'd1;
        strides = {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd7};
        ranges  = {32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd0};
        push(16'h1234, 1);
        start_pass(0);
        wait_done(20, 0, cyc);
        end_checks("range0", 32'd1);

        // dimensionality 0 behaves as 1: dim 1 (range 2) ignored
        starting_addr = 16'h0000; dimensionality = 4'd0;
        strides = {16'd0, 16'd0, 16'd0, 16'd0, 16'd5, 16'd2};
        ranges  = {32'd1, 32'd1, 32'd1, 32'd1, 32'd2, 32'd3};
        push(16'd0, 0); push(16'd2, 0); push(16'd4, 1);
        start_pass(0);
        wait_done(20, 0, cyc);
        end_checks("dim0", 32'd3);

        // dimensionality 9 clamps to 6: dims 0 and 5 both step
        starting_addr = 16'h0010; dimensionality = 4'd9;
        strides = {16'h0100, 16'd7, 16'd7, 16'd7, 16'd7, 16'd1};
        ranges  = {32'd2, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2};
        push(16'h0010, 0); push(16'h0011, 0); push(16'h0110, 0); push(16'h0111, 1);
        start_pass(0);
        wait_done(20, 0, cyc);
        end_checks("dim9", 32'd4);

        // start held through the pass and the done cycle: no second pass
        cfg_2x2(); push_2x2();
        drop_start_on_done = 1;
        start_pass(1);
        wait_done(20, 0, cyc);
        repeat (3) tick();
        end_checks("held_start", 32'd4);

        // reset mid-pass
        cfg_cube(); push_cube();
        start_pass(0);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        check_idle_outputs("mid_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
